fm_delay_ctrl: RTL and testbench

Consumer end of the FMC frequency comparator. It takes the Sel decision that FMC produces once per DIV_M period and steers the delay-line control code of the FMDLL. A coarse/fine/locked state machine decides how the code moves and raises a lock flag. The block sits in the CLK_out domain and drives the delay line's code bus.

---
 rtl/fm_dll_pkg.sv | 18 +
 rtl/fm_sync_edge.sv | 28 ++
 rtl/fm_delay_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_fm_delay_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fm_dll_pkg.sv
// Shared definitions for the FMDLL control path: FMC decision encoding,
// control-state encoding and the default delay-code width.
package fm_dll_pkg;

    localparam int unsigned CODE_W_DEF = 6;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_UP   = 2'b01;
    localparam logic [1:0] SEL_DN   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_COARSE = 2'b01,
        ST_FINE   = 2'b10,
        ST_LOCKED = 2'b11
    } state_t;

endpackage

// File: rtl/fm_sync_edge.sv
// Two-flop synchroniser for an asynchronous level, followed by a
// rising-edge detector that pulses for one cycle per synchronised rise.
module fm_sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/fm_delay_ctrl.sv
// FMDLL delay-code controller: turns FMC Sel decisions (one per DIV_M rise)
// into coarse/fine code steps with saturation and lock detection.
module fm_delay_ctrl
    import fm_dll_pkg::*;
#(
    parameter int unsigned CODE_W      = CODE_W_DEF,
    parameter int unsigned COARSE_STEP = 4,
    parameter int unsigned FILT_N      = 4,
    parameter int unsigned LOCK_CNT    = 8
) (
    input  logic              CLK_out,
    input  logic              rst,
    input  logic              en,
    input  logic              DIV_M,
    input  logic [1:0]        Sel,
    output logic [CODE_W-1:0] code,
    output logic              lock,
    output logic [1:0]        state,
    output logic              step_pulse,
    output logic              sat
);

    localparam int unsigned FCNT_W = $clog2(FILT_N + 1);
    localparam int unsigned QCNT_W = $clog2(LOCK_CNT + 1);

    localparam logic [CODE_W-1:0] MID    = {1'b1, {(CODE_W-1){1'b0}}};
    localparam logic [CODE_W:0]   MAX_C  = {1'b0, {CODE_W{1'b1}}};
    localparam logic [CODE_W:0]   STEP_C = (CODE_W+1)'(COARSE_STEP);
    localparam logic [CODE_W:0]   ONE_C  = (CODE_W+1)'(1);
    localparam logic [FCNT_W-1:0] FTOP   = FCNT_W'(FILT_N);
    localparam logic [QCNT_W-1:0] QLAST  = QCNT_W'(LOCK_CNT - 1);

    logic              w_rise;
    logic [1:0]        r_sel_s1;
    logic [1:0]        r_sel_s2;
    logic              r_dec_vld;
    logic [1:0]        r_dec;

    state_t            r_state;
    logic [CODE_W-1:0] r_code;
    logic              r_lock;
    logic              r_step;
    logic              r_sat;
    logic              r_last_vld;
    logic              r_last_up;
    logic              r_fdir_up;
    logic [FCNT_W-1:0] r_fcnt;
    logic [QCNT_W-1:0] r_qcnt;

    logic              w_up;
    logic              w_dn;
    logic              w_move;
    logic              w_rev;
    logic              w_at_bound;
    logic              w_clamp;
    logic              w_fstep;
    logic [CODE_W:0]   w_mag;
    logic [CODE_W:0]   w_wide;
    logic [CODE_W-1:0] w_tgt;
    logic [FCNT_W-1:0] w_fcnt_nx;

    fm_sync_edge u_div_sync (
        .i_clk  (CLK_out),
        .i_rst  (rst),
        .i_d    (DIV_M),
        .o_rise (w_rise)
    );

    // Sel is latched on the detected edge; it is stable well before DIV_M rises.
    always_ff @(posedge CLK_out or posedge rst) begin
        if (rst) begin
            r_sel_s1  <= '0;
            r_sel_s2  <= '0;
            r_dec_vld <= 1'b0;
            r_dec     <= '0;
        end else begin
            r_sel_s1  <= Sel;
            r_sel_s2  <= r_sel_s1;
            r_dec_vld <= w_rise & en;
            if (w_rise) begin
                r_dec <= r_sel_s2;
            end
        end
    end

    assign w_up       = (r_dec == SEL_UP);
    assign w_dn       = (r_dec == SEL_DN);
    assign w_move     = r_dec_vld & (w_up | w_dn);
    assign w_rev      = w_move & r_last_vld & (r_last_up != w_up);
    assign w_at_bound = (w_up & (r_code == '1)) | (w_dn & (r_code == '0));

    always_comb begin
        w_mag   = (r_state == ST_COARSE && !w_rev) ? STEP_C : ONE_C;
        w_wide  = {1'b0, r_code};
        w_tgt   = r_code;
        w_clamp = 1'b0;
        if (w_up) begin
            w_wide = {1'b0, r_code} + w_mag;
            if (w_wide > MAX_C) begin
                w_tgt   = '1;
                w_clamp = 1'b1;
            end else begin
                w_tgt = w_wide[CODE_W-1:0];
            end
        end else if (w_dn) begin
            if ({1'b0, r_code} < w_mag) begin
                w_tgt   = '0;
                w_clamp = 1'b1;
            end else begin
                w_wide = {1'b0, r_code} - w_mag;
                w_tgt  = w_wide[CODE_W-1:0];
            end
        end
    end

    always_comb begin
        w_fcnt_nx = '0;
        if (w_move) begin
            if (r_fcnt != '0 && r_fdir_up == w_up) begin
                w_fcnt_nx = r_fcnt + 1'b1;
            end else begin
                w_fcnt_nx = FCNT_W'(1);
            end
        end
    end

    assign w_fstep = w_move & (w_fcnt_nx == FTOP);

    always_ff @(posedge CLK_out or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_code     <= MID;
            r_lock     <= 1'b0;
            r_step     <= 1'b0;
            r_sat      <= 1'b0;
            r_last_vld <= 1'b0;
            r_last_up  <= 1'b0;
            r_fdir_up  <= 1'b0;
            r_fcnt     <= '0;
            r_qcnt     <= '0;
        end else begin
            r_step <= 1'b0;
            if (!en) begin
                r_state    <= ST_IDLE;
                r_lock     <= 1'b0;
                r_last_vld <= 1'b0;
                r_fcnt     <= '0;
                r_qcnt     <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_COARSE;
                    end
                    ST_COARSE: begin
                        if (w_move) begin
                            r_code     <= w_tgt;
                            r_step     <= (w_tgt != r_code);
                            r_sat      <= w_clamp;
                            r_last_vld <= 1'b1;
                            r_last_up  <= w_up;
                            if (w_rev || w_clamp) begin
                                r_state <= ST_FINE;
                                r_fcnt  <= '0;
                                r_qcnt  <= '0;
                            end
                        end else if (r_dec_vld) begin
                            r_sat <= 1'b0;
                        end
                    end
                    ST_FINE, ST_LOCKED: begin
                        if (r_dec_vld) begin
                            r_fdir_up <= w_up;
                            if (w_fstep) begin
                                r_code <= w_tgt;
                                r_step <= (w_tgt != r_code);
                                r_sat  <= w_clamp;
                                r_fcnt <= '0;
                                r_qcnt <= '0;
                                if (r_state == ST_LOCKED) begin
                                    r_state <= ST_FINE;
                                    r_lock  <= 1'b0;
                                end
                            end else begin
                                r_fcnt <= w_fcnt_nx;
                                r_sat  <= w_at_bound;
                                if (r_state == ST_FINE) begin
                                    if (r_qcnt == QLAST) begin
                                        r_state <= ST_LOCKED;
                                        r_lock  <= 1'b1;
                                        r_qcnt  <= '0;
                                    end else begin
                                        r_qcnt <= r_qcnt + 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign code       = r_code;
    assign lock       = r_lock;
    assign state      = r_state;
    assign step_pulse = r_step;
    assign sat        = r_sat;

endmodule

// File: tb/tb_fm_delay_ctrl.sv
// Scoreboard bench for fm_delay_ctrl: decisions push expected outcomes from a
// behavioural loop model; a monitor compares them when the results fall due.
module tb_fm_delay_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       divm;
    logic [1:0] sel;
    logic [5:0] code;
    logic       lock;
    logic [1:0] state;
    logic       sp;
    logic       sat;

    fm_delay_ctrl #(
        .CODE_W      (6),
        .COARSE_STEP (4),
        .FILT_N      (4),
        .LOCK_CNT    (8)
    ) dut (
        .CLK_out    (clk),
        .rst        (rst),
        .en         (en),
        .DIV_M      (divm),
        .Sel        (sel),
        .code       (code),
        .lock       (lock),
        .state      (state),
        .step_pulse (sp),
        .sat        (sat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int due;
        int code;
        int st;
        int lock;
        int sat;
        int pulse;
    } exp_t;
    exp_t q[$];

    // Reference model: 0 idle, 1 coarse, 2 fine, 3 locked; s = +1 up, -1 down, 0 hold
    int m_code, m_state, m_lock, m_sat, m_pulse, m_last, m_run, m_quiet;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        m_code = 32; m_state = 0; m_lock = 0; m_sat = 0; m_pulse = 0;
        m_last = 0; m_run = 0; m_quiet = 0;
    endfunction

    function automatic int apply(int d);
        int t;
        int c;
        t = m_code + d;
        c = 0;
        if (t > 63) begin t = 63; c = 1; end
        else if (t < 0) begin t = 0; c = 1; end
        m_pulse = (t != m_code);
        m_code  = t;
        m_sat   = c;
        return c;
    endfunction

    function automatic void model_decide(int s);
        m_pulse = 0;
        if (m_state == 0) return;
        if (m_state == 1) begin
            if (s == 0) m_sat = 0;
            else if (m_last != 0 && s != m_last) begin
                void'(apply(s));
                m_state = 2; m_run = 0; m_quiet = 0;
            end else if (apply(4 * s) != 0) begin
                m_state = 2; m_run = 0; m_quiet = 0;
            end
            if (s != 0) m_last = s;
        end else begin
            if (s == 0) m_run = 0;
            else if (m_run * s > 0) m_run += s;
            else m_run = s;
            if (m_run == 4 || m_run == -4) begin
                void'(apply(s));
                m_run = 0; m_quiet = 0;
                if (m_state == 3) begin m_state = 2; m_lock = 0; end
            end else begin
                m_sat = ((s > 0 && m_code == 63) || (s < 0 && m_code == 0)) ? 1 : 0;
                if (m_state == 2) begin
                    m_quiet++;
                    if (m_quiet == 8) begin m_state = 3; m_lock = 1; m_quiet = 0; end
                end
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic decide(input logic [1:0] s);
        exp_t e;
        sel  = s;
        divm = 1'b1;
        model_decide(s == 2'b01 ? 1 : (s == 2'b10 ? -1 : 0));
        e.due = cyc + 4; e.code = m_code; e.st = m_state;
        e.lock = m_lock; e.sat = m_sat; e.pulse = m_pulse;
        q.push_back(e);
        repeat (4) tick();
        divm = 1'b0;
        repeat (5) tick();
    endtask

    task automatic set_en(input logic v);
        en = v;
        tick();
        if (v) begin
            if (m_state == 0) m_state = 1;
        end else begin
            m_state = 0; m_lock = 0; m_last = 0; m_run = 0; m_quiet = 0;
        end
        chk("en_state", state, m_state);
        chk("en_lock", lock, m_lock);
        chk("en_code", code, m_code);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                chk("due_cycle", cyc, e.due);
                chk("code", code, e.code);
                chk("state", state, e.st);
                chk("lock", lock, e.lock);
                chk("sat", sat, e.sat);
                chk("step_pulse", sp, e.pulse);
            end else if (sp) begin
                chk("spurious_step_pulse", sp, 0);
            end
        end
    end

    initial begin : stim
        logic [1:0] s;
        rst = 1'b1; en = 1'b0; divm = 1'b0; sel = 2'b00;
        model_reset();
        repeat (3) tick();
        chk("rst_code", code, 32);
        chk("rst_state", state, 0);
        chk("rst_lock", lock, 0);
        chk("rst_sat", sat, 0);
        chk("rst_step", sp, 0);
        rst = 1'b0;
        tick();
        set_en(1'b1);

        repeat (3) decide(2'b01);           // 36, 40, 44
        decide(2'b10);                      // 43, FINE
        repeat (4) decide(2'b01);           // filtered, then 44
        for (int i = 0; i < 8; i++) decide(i % 2 == 0 ? 2'b10 : 2'b01);  // lock
        repeat (4) decide(2'b10);           // 43, unlock
        decide(2'b11);                      // invalid treated as hold
        decide(2'b01);
        set_en(1'b0);
        decide(2'b01);
        decide(2'b10);

        // Async reset while a DIV_M rise is part-way through the synchroniser
        sel = 2'b01; divm = 1'b1;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_code", code, 32);
        chk("arst_state", state, 0);
        chk("arst_lock", lock, 0);
        divm = 1'b0;
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        repeat (8) tick();
        chk("post_rst_code", code, 32);

        set_en(1'b1);
        repeat (8) decide(2'b01);           // 36..60, then clamp at 63
        decide(2'b01);                      // no step, sat held

        s = 2'b00;
        for (int i = 0; i < 90; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                set_en(1'b0);
                if ($urandom_range(0, 1) == 1) decide(2'(($urandom_range(0, 3))));
                set_en(1'b1);
            end
            if ($urandom_range(0, 3) == 0) s = 2'($urandom_range(0, 3));
            decide(s);
        end

        for (int i = 0; i < 50 && q.size() > 0; i++) tick();
        if (q.size() != 0) chk("scoreboard_drain", q.size(), 0);
        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
